// File: rtl/packet_retry_tx.sv
`default_nettype none
// ============================================================================
// Module : packet_retry_tx
// Forwards packets from a replay-capable FIFO and retires or replays each one
// based on link ack/nak, with a response timeout and a bounded retry count.
// Rev    : 1.0
// ============================================================================
module packet_retry_tx #(
  parameter int WIDTH      = 8,
  parameter int TIMEOUT    = 1024,
  parameter int MAX_RETRY  = 3,
  parameter int REPLAY_GAP = 2,
  parameter int TBITS      = $clog2(TIMEOUT + 1),
  parameter int RBITS      = $clog2(MAX_RETRY + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             redo_o,
  output logic             next_o,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [WIDTH-1:0] m_tdata,
  input  logic             ack_i,
  input  logic             nak_i,
  output logic             busy_o,
  output logic             fail_o,
  output logic [RBITS-1:0] retries_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam int GBITS = (REPLAY_GAP > 1) ? $clog2(REPLAY_GAP) : 1;
  localparam logic [TBITS-1:0] c_TIMER_LAST = TBITS'(TIMEOUT - 1);
  localparam logic [RBITS-1:0] c_RETRY_MAX  = RBITS'(MAX_RETRY);
  localparam logic [GBITS-1:0] c_GAP_LAST   = GBITS'((REPLAY_GAP > 0) ? REPLAY_GAP - 1 : 0);

  state_t           r_state;
  logic [TBITS-1:0] r_timer;
  logic [RBITS-1:0] r_retry;
  logic [GBITS-1:0] r_gap;
  logic             r_redo;
  logic             r_next;
  logic             r_fail;

  logic w_send;
  logic w_last_beat;
  logic w_expired;
  logic w_nak_event;
  logic w_can_retry;

  assign w_send      = (r_state == S_SEND);
  assign w_last_beat = w_send & s_tvalid & m_tready & s_tlast;
  assign w_expired   = (r_timer == c_TIMER_LAST);
  // nak beats ack; ack beats a simultaneous timer expiry
  assign w_nak_event = nak_i | (w_expired & ~ack_i);
  assign w_can_retry = (r_retry < c_RETRY_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_retry <= '0;
      r_gap   <= '0;
      r_redo  <= 1'b0;
      r_next  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_redo <= 1'b0;
      r_next <= 1'b0;
      r_fail <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (s_tvalid) r_state <= S_SEND;
        end
        S_SEND: begin
          if (w_last_beat) begin
            r_state <= S_WAIT;
            r_timer <= '0;
          end
        end
        S_WAIT: begin
          if (w_nak_event) begin
            if (w_can_retry) begin
              r_redo  <= 1'b1;
              r_retry <= r_retry + RBITS'(1);
              r_gap   <= '0;
              if (REPLAY_GAP > 0) r_state <= S_GAP;
              else                r_state <= S_SEND;
            end else begin
              r_next  <= 1'b1;
              r_fail  <= 1'b1;
              r_retry <= '0;
              r_state <= S_IDLE;
            end
          end else if (ack_i) begin
            r_next  <= 1'b1;
            r_retry <= '0;
            r_state <= S_IDLE;
          end else if (!w_expired) begin
            r_timer <= r_timer + TBITS'(1);
          end
        end
        S_GAP: begin
          // hold off while the FIFO reloads its read pointer
          if (r_gap == c_GAP_LAST) r_state <= S_SEND;
          else                     r_gap   <= r_gap + GBITS'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_tready  = w_send & m_tready;
  assign m_tvalid  = w_send & s_tvalid;
  assign m_tlast   = w_send & s_tvalid & s_tlast;
  assign m_tdata   = s_tdata;
  assign busy_o    = (r_state != S_IDLE);
  assign redo_o    = r_redo;
  assign next_o    = r_next;
  assign fail_o    = r_fail;
  assign retries_o = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_packet_retry_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_packet_retry_tx
// Randomized bench for packet_retry_tx against a timestamp-based reference.
// Rev    : 1.0
// ============================================================================
module tb_packet_retry_tx;

  localparam int WIDTH      = 8;
  localparam int TIMEOUT    = 16;
  localparam int MAX_RETRY  = 3;
  localparam int REPLAY_GAP = 2;
  localparam int RBITS      = $clog2(MAX_RETRY + 1);
  localparam int NPKT       = 36;
  localparam int RST_PKT    = NPKT - 1;
  localparam int MAXLEN     = 12;
  localparam int LIMIT      = 40000;
  localparam int K_ACK      = 0;
  localparam int K_NAK      = 1;
  localparam int K_BOTH     = 2;
  localparam int K_NONE     = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             s_tvalid = 1'b0;
  logic             s_tready;
  logic             s_tlast = 1'b0;
  logic [WIDTH-1:0] s_tdata = '0;
  logic             redo_o;
  logic             next_o;
  logic             m_tvalid;
  logic             m_tready = 1'b0;
  logic             m_tlast;
  logic [WIDTH-1:0] m_tdata;
  logic             ack_i = 1'b0;
  logic             nak_i = 1'b0;
  logic             busy_o;
  logic             fail_o;
  logic [RBITS-1:0] retries_o;

  always #5 clock = ~clock;

  packet_retry_tx #(
    .WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .REPLAY_GAP(REPLAY_GAP)
  ) u_dut (
    .clock(clock), .reset(reset),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tdata(s_tdata),
    .redo_o(redo_o), .next_o(next_o),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tdata(m_tdata),
    .ack_i(ack_i), .nak_i(nak_i),
    .busy_o(busy_o), .fail_o(fail_o), .retries_o(retries_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // packet store seen by the bench-side FIFO
  logic [WIDTH-1:0] pkt_mem [NPKT][MAXLEN];
  int               pkt_len [NPKT];
  int               pkt_mode[NPKT];
  int               plan_kind[$];
  int               plan_d[$];

  // reference: expected events are kept as absolute cycle numbers
  int cyc, head, idx, exp_retries, pass_from, pulse_at, resp_cyc, resp_kind, tail, d, mode;
  bit idle, pend, rst_pend, pass_now, have;
  bit exp_redo, exp_next, exp_fail;

  task automatic plan(input int kind, input int dly);
    plan_kind.push_back(kind);
    plan_d.push_back(dly);
  endtask

  initial begin
    for (int p = 0; p < NPKT; p++) begin
      pkt_len[p]  = (p < 4 || p == RST_PKT) ? 4 : (p == 4) ? 8 : int'($urandom_range(1, MAXLEN));
      pkt_mode[p] = (p == 4) ? 1 : (p < 4 || p == RST_PKT) ? 0 : 2;
      for (int w = 0; w < MAXLEN; w++) pkt_mem[p][w] = WIDTH'($urandom);
    end
    for (int w = 0; w < MAXLEN; w++) pkt_mem[1][w] = pkt_mem[0][w];

    plan(K_ACK, 4);
    plan(K_NAK, 2);  plan(K_ACK, 3);
    plan(K_NONE, TIMEOUT - 1); plan(K_NONE, TIMEOUT - 1);
    plan(K_NONE, TIMEOUT - 1); plan(K_NONE, TIMEOUT - 1);
    plan(K_BOTH, 1); plan(K_ACK, TIMEOUT - 1);
    plan(K_ACK, 2);

    // reset state, with inputs that would otherwise provoke activity
    repeat (2) @(posedge clock);
    #1;
    s_tvalid = 1'b1; m_tready = 1'b1; ack_i = 1'b1; nak_i = 1'b1;
    @(negedge clock);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_busy",     32'(busy_o),   32'd0);
    check("rst_redo",     32'(redo_o),   32'd0);
    check("rst_next",     32'(next_o),   32'd0);
    check("rst_fail",     32'(fail_o),   32'd0);
    check("rst_retries",  32'(retries_o), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0; s_tvalid = 1'b0; ack_i = 1'b0; nak_i = 1'b0;

    head = 0; idx = 0; exp_retries = 0; pass_from = -1; pulse_at = -1; resp_cyc = -1;
    resp_kind = K_ACK; tail = 0; idle = 1'b1; pend = 1'b0; rst_pend = 1'b0;
    cyc = 0;
    while (cyc < LIMIT && tail <= 6) begin
      @(posedge clock);
      #1;
      exp_redo = 1'b0; exp_next = 1'b0; exp_fail = 1'b0;
      if (rst_pend) begin
        rst_pend = 1'b0; reset = 1'b0;
        idle = 1'b1; pend = 1'b0; pass_from = -1; exp_retries = 0; head = NPKT; idx = 0;
      end else if (pend && cyc == pulse_at) begin
        pend = 1'b0;
        if (resp_kind == K_ACK) begin
          exp_next = 1'b1; exp_retries = 0; head++; idx = 0; idle = 1'b1;
        end else if (exp_retries < MAX_RETRY) begin
          exp_redo = 1'b1; exp_retries++; idx = 0; pass_from = cyc + REPLAY_GAP;
        end else begin
          exp_next = 1'b1; exp_fail = 1'b1; exp_retries = 0; head++; idx = 0; idle = 1'b1;
        end
      end

      pass_now = !idle && pass_from >= 0 && cyc >= pass_from;
      have     = head < NPKT && !pend && idx < pkt_len[head];
      mode     = (head < NPKT) ? pkt_mode[head] : 0;
      s_tvalid = have && (mode != 2 || $urandom_range(0, 3) != 0);
      s_tdata  = have ? pkt_mem[head][idx] : WIDTH'($urandom);
      s_tlast  = have && s_tvalid && (idx == pkt_len[head] - 1);
      m_tready = (mode == 1) ? cyc[0] : (mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (pend) begin
        ack_i = (cyc == resp_cyc) && (resp_kind == K_ACK || resp_kind == K_BOTH);
        nak_i = (cyc == resp_cyc) && (resp_kind == K_NAK || resp_kind == K_BOTH);
      end else begin
        ack_i = ($urandom_range(0, 7) == 0);
        nak_i = ($urandom_range(0, 7) == 0);
      end
      if (head == RST_PKT && exp_retries == 1 && pass_now && idx == 1 && s_tvalid) begin
        reset = 1'b1; rst_pend = 1'b1;
      end

      @(negedge clock);
      check("redo_o",    32'(redo_o),    32'(exp_redo));
      check("next_o",    32'(next_o),    32'(exp_next));
      check("fail_o",    32'(fail_o),    32'(exp_fail));
      check("retries_o", 32'(retries_o), 32'(exp_retries));
      check("busy_o",    32'(busy_o),    32'(!idle));
      check("m_tvalid",  32'(m_tvalid),  32'(pass_now && s_tvalid));
      check("s_tready",  32'(s_tready),  32'(pass_now && m_tready));
      check("m_tlast",   32'(m_tlast),   32'(pass_now && s_tvalid && s_tlast));
      if (pass_now && s_tvalid && m_tready) begin
        check("m_tdata", 32'(m_tdata), 32'(pkt_mem[head][idx]));
        idx++;
        if (s_tlast) begin
          if (plan_kind.size() > 0) begin
            resp_kind = plan_kind.pop_front();
            d         = plan_d.pop_front();
          end else if (head == RST_PKT) begin
            resp_kind = K_NAK; d = 0;
          end else begin
            case ($urandom_range(0, 7))
              0, 1, 2: begin resp_kind = K_ACK;  d = int'($urandom_range(0, TIMEOUT - 1)); end
              3, 4:    begin resp_kind = K_NAK;  d = int'($urandom_range(0, 5)); end
              5:       begin resp_kind = K_BOTH; d = int'($urandom_range(0, 5)); end
              6:       begin resp_kind = K_NONE; d = TIMEOUT - 1; end
              default: begin resp_kind = K_ACK;  d = TIMEOUT - 1; end
            endcase
          end
          resp_cyc  = cyc + 1 + d;
          pulse_at  = resp_cyc + 1;
          pend      = 1'b1;
          pass_from = -1;
        end
      end else if (idle && s_tvalid) begin
        idle      = 1'b0;
        pass_from = cyc + 1;
      end
      if (head >= NPKT) tail++;
      cyc++;
    end
    check("all_packets_retired", 32'(head), 32'(NPKT));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
